finn_input_packer: RTL and testbench
====================================

# finn_input_packer

Upstream width adapter for the `finn_design` accelerator. It takes a byte-wide AXI4-Stream of pixels/features and packs `LANES` consecutive beats into one `LANES*IN_W`-bit word (40 bits by default) on the accelerator's `s_axis_0` port. Frames end on `s_axis_tlast`; a partial final word is zero-padded and flagged. The block is registered-output, runs at one input beat per cycle, and adds no bubbles between words.

## Interface
Parameters:
- `IN_W`, default 8: input beat width in bits.
- `LANES`, default 5: beats per output word. Must be ≥ 2. Output width is `LANES*IN_W`.

Ports:
- `ap_clk`, in, 1: single clock; everything is on its rising edge.
- `ap_rst`, in, 1: reset. Synchronous and active-high.
- `s_axis_tdata`, in, `IN_W`: input beat.
- `s_axis_tvalid`, in, 1: input valid.
- `s_axis_tready`, out, 1: input ready.
- `s_axis_tlast`, in, 1: last beat of frame.
- `m_axis_0_tdata`, out, `LANES*IN_W`: packed word; connects to `finn_design.s_axis_0_tdata`.
- `m_axis_0_tvalid`, out, 1: word valid.
- `m_axis_0_tready`, in, 1: downstream ready.
- `m_axis_0_tkeep`, out, `LANES`: one bit per lane; 1 = lane holds a real beat.
- `m_axis_0_tlast`, out, 1: word closes a frame.

## Operation
- **State.**
  - `lane_cnt`: 0..`LANES`-1, the next lane to fill.
  - `acc`: `LANES*IN_W` bits, the partial word.
  - `acc_keep`: `LANES` bits.
  - Output register: `out_data`, `out_keep`, `out_last`, `out_valid`, driving the `m_axis_0_*` outputs directly.
- **Lane order.** The first beat of a word goes to bits `[IN_W-1:0]` (lane 0). Beat `k` goes to `[(k+1)*IN_W-1 : k*IN_W]`.
- **Ready.** `s_axis_tready = !ap_rst && (!out_valid || m_axis_0_tready)`. It is combinational and does not depend on `s_axis_tvalid` or `s_axis_tlast`.
- **Accept.** A beat is accepted when `s_axis_tvalid && s_axis_tready`.
  - *Non-completing beat* (`lane_cnt < LANES-1` and `!s_axis_tlast`):
    - write the beat into lane `lane_cnt` of `acc`;
    - set `acc_keep[lane_cnt]`;
    - increment `lane_cnt`.
  - *Completing beat* (`lane_cnt == LANES-1`, or `s_axis_tlast`):
    - `out_data` = `acc` with the beat merged into lane `lane_cnt`; lanes above `lane_cnt` are 0;
    - `out_keep` = `acc_keep` with bit `lane_cnt` set;
    - `out_last` = `s_axis_tlast`;
    - `out_valid` = 1;
    - clear `acc` and `acc_keep`, and set `lane_cnt` to 0.
- **Drain.** If `out_valid && m_axis_0_tready` with no completing beat in the same cycle, `out_valid` goes to 0. A drain and a completion in the same cycle load the new word, and `out_valid` stays 1.
- **Beat arithmetic.** No arithmetic on data.
- **Frame boundaries.**
  - A frame that ends exactly on lane `LANES-1` gives a full word with `tkeep` all ones and `tlast` = 1.
  - A one-beat frame gives `tkeep` = 1 (lane 0 only) and `tlast` = 1.
- **Reset.**
  - Clears `out_valid`, `out_data`, `out_keep`, `out_last`, `acc`, `acc_keep` and `lane_cnt` to 0.
  - Asserted mid-word: the partial word is discarded and never emitted.
  - Asserted while `out_valid` = 1: the held word is dropped.

## Timing
- **Outputs under reset.** `m_axis_0_tvalid`, `m_axis_0_tdata`, `m_axis_0_tkeep` and `m_axis_0_tlast` are 0. `s_axis_tready` is 0 while `ap_rst` = 1 and is 1 in the first cycle after release.
- **Latency.** `m_axis_0_tvalid` rises in the cycle after the rising edge that accepts the completing beat, i.e. 1 cycle.
- **Throughput.** With `m_axis_0_tready` held at 1, one beat is accepted every cycle and one word is emitted every `LANES` cycles, with no stall.
- **Backpressure.** While `out_valid && !m_axis_0_tready`:
  - `s_axis_tready` = 0;
  - all `m_axis_0_*` outputs hold stable (AXI rule);
  - `acc` and `lane_cnt` do not change.
- `s_axis_tvalid` may drop between beats; the packer simply waits with its state unchanged.

## Test plan
- **Pack one word.** Reset for 10 cycles, then send bytes DE, BC, 0A, 00, 00 (no tlast), `m_axis_0_tready` = 1.
  - Required: exactly one word, 40'h00000ABCDE, `tkeep` = 5'b11111, `tlast` = 0, valid 1 cycle after the 5th accept.
- **Continuous stream.** 10 bytes 01..0A back-to-back, `tlast` on 0A, `tready` = 1.
  - Required: words 40'h0504030201 (`tlast` 0) and 40'h0A09080706 (`tlast` 1).
  - `s_axis_tready` stays 1 throughout.
- **Short frame.** Bytes AA, BB with `tlast` on BB.
  - Required: word 40'h000000BBAA, `tkeep` = 5'b00011, `tlast` = 1.
  - The next byte 11 lands in lane 0 of a fresh word.
- **Backpressure.** Complete a word with `m_axis_0_tready` = 0 held for 6 cycles.
  - Required: data, `tkeep` and `tlast` stable; `s_axis_tready` = 0 for all 6 cycles.
  - After `tready` rises, the word transfers in 1 cycle and input resumes the same cycle.
- **Reset mid-word.** Send 3 bytes, pulse `ap_rst` for 1 cycle, then send bytes 10..14.
  - Required: a single word 40'h1413121110; the first 3 bytes never appear.
- **Random valid/ready.** Random `s_axis_tvalid` and `m_axis_0_tready` with frames of random length 1–12, checked against a scoreboard model.
  - Required: no beat lost or duplicated.
  - Every word's `tkeep`, `tlast` and zero padding match the model.

Source files
------------

// File: rtl/finn_input_packer.sv
// Packs LANES consecutive IN_W-bit AXI4-Stream beats into one LANES*IN_W-bit word.
// A frame-final partial word is zero-padded and flagged through tkeep/tlast.
module finn_input_packer #(
  parameter int IN_W  = 8,
  parameter int LANES = 5
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic [IN_W-1:0]       s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic [LANES*IN_W-1:0] m_axis_0_tdata,
  output logic                  m_axis_0_tvalid,
  input  logic                  m_axis_0_tready,
  output logic [LANES-1:0]      m_axis_0_tkeep,
  output logic                  m_axis_0_tlast
);

  localparam int OUT_W = LANES * IN_W;
  localparam int CNT_W = $clog2(LANES);
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(LANES - 1);

  logic [CNT_W-1:0] lane_cnt;
  logic [OUT_W-1:0] acc;
  logic [LANES-1:0] acc_keep;
  logic [OUT_W-1:0] out_data;
  logic [LANES-1:0] out_keep;
  logic             out_last;
  logic             out_valid;

  logic [OUT_W-1:0] merged_data;
  logic [LANES-1:0] merged_keep;
  logic             accept;
  logic             complete;

  assign s_axis_tready = !ap_rst && (!out_valid || m_axis_0_tready);
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign complete      = accept && ((lane_cnt == LAST_LANE) || s_axis_tlast);

  // Lanes above lane_cnt in acc are always zero, so merging yields the padding for free.
  always_comb begin
    merged_data = acc;
    merged_keep = acc_keep;
    for (int i = 0; i < LANES; i++) begin
      if (lane_cnt == CNT_W'(i)) begin
        merged_data[i*IN_W +: IN_W] = s_axis_tdata;
        merged_keep[i]              = 1'b1;
      end
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      lane_cnt  <= '0;
      acc       <= '0;
      acc_keep  <= '0;
      out_data  <= '0;
      out_keep  <= '0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
    end else if (complete) begin
      out_data  <= merged_data;
      out_keep  <= merged_keep;
      out_last  <= s_axis_tlast;
      out_valid <= 1'b1;
      acc       <= '0;
      acc_keep  <= '0;
      lane_cnt  <= '0;
    end else begin
      if (accept) begin
        acc      <= merged_data;
        acc_keep <= merged_keep;
        lane_cnt <= lane_cnt + CNT_W'(1);
      end
      if (out_valid && m_axis_0_tready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign m_axis_0_tdata  = out_data;
  assign m_axis_0_tkeep  = out_keep;
  assign m_axis_0_tlast  = out_last;
  assign m_axis_0_tvalid = out_valid;

endmodule

// File: tb/tb_finn_input_packer.sv
// Bench for finn_input_packer: directed literal cases plus random valid/ready frames
// checked against a beat-chunking reference model.
module tb_finn_input_packer;

  localparam int IN_W  = 8;
  localparam int LANES = 5;
  localparam int OUT_W = LANES * IN_W;

  typedef struct {
    logic [OUT_W-1:0] data;
    logic [LANES-1:0] keep;
    logic             last;
  } word_t;

  logic             ap_clk = 1'b0;
  logic             ap_rst;
  logic [IN_W-1:0]  s_axis_tdata;
  logic             s_axis_tvalid;
  logic             s_axis_tready;
  logic             s_axis_tlast;
  logic [OUT_W-1:0] m_axis_0_tdata;
  logic             m_axis_0_tvalid;
  logic             m_axis_0_tready;
  logic [LANES-1:0] m_axis_0_tkeep;
  logic             m_axis_0_tlast;

  int checks = 0;
  int errors = 0;

  logic [IN_W-1:0] pending[$];
  word_t           expq[$];
  word_t           got[$];
  bit              watch_ready = 1'b0;
  bit              rand_ready  = 1'b0;
  bit              hold_prev   = 1'b0;
  bit              rst_prev    = 1'b0;
  word_t           held;

  finn_input_packer #(.IN_W(IN_W), .LANES(LANES)) dut (
    .ap_clk          (ap_clk),
    .ap_rst          (ap_rst),
    .s_axis_tdata    (s_axis_tdata),
    .s_axis_tvalid   (s_axis_tvalid),
    .s_axis_tready   (s_axis_tready),
    .s_axis_tlast    (s_axis_tlast),
    .m_axis_0_tdata  (m_axis_0_tdata),
    .m_axis_0_tvalid (m_axis_0_tvalid),
    .m_axis_0_tready (m_axis_0_tready),
    .m_axis_0_tkeep  (m_axis_0_tkeep),
    .m_axis_0_tlast  (m_axis_0_tlast)
  );

  always #5 ap_clk = ~ap_clk;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  // Inputs change just after posedge, so the negedge view is exactly what the next edge samples.
  always @(negedge ap_clk) begin
    word_t cur;
    word_t w;
    cur.data = m_axis_0_tdata;
    cur.keep = m_axis_0_tkeep;
    cur.last = m_axis_0_tlast;
    if (ap_rst) begin
      check("rst_s_tready", 64'(s_axis_tready), 64'(0));
      if (rst_prev) begin
        check("rst_m_tvalid", 64'(m_axis_0_tvalid), 64'(0));
        check("rst_m_tdata", 64'(m_axis_0_tdata), 64'(0));
        check("rst_m_tkeep", 64'(m_axis_0_tkeep), 64'(0));
        check("rst_m_tlast", 64'(m_axis_0_tlast), 64'(0));
      end
      pending.delete();
      expq.delete();
      hold_prev = 1'b0;
      rst_prev  = 1'b1;
    end else begin
      rst_prev = 1'b0;
      check("tready_rule", 64'(s_axis_tready), 64'(!m_axis_0_tvalid || m_axis_0_tready));
      if (watch_ready) check("stream_tready", 64'(s_axis_tready), 64'(1));
      if (hold_prev) begin
        check("hold_tvalid", 64'(m_axis_0_tvalid), 64'(1));
        check("hold_tdata", 64'(cur.data), 64'(held.data));
        check("hold_tkeep", 64'(cur.keep), 64'(held.keep));
        check("hold_tlast", 64'(cur.last), 64'(held.last));
      end
      hold_prev = m_axis_0_tvalid && !m_axis_0_tready;
      held      = cur;
      if (m_axis_0_tvalid && m_axis_0_tready) begin
        got.push_back(cur);
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got %0h, expected no word", cur.data);
        end else begin
          w = expq.pop_front();
          check("model_tdata", 64'(cur.data), 64'(w.data));
          check("model_tkeep", 64'(cur.keep), 64'(w.keep));
          check("model_tlast", 64'(cur.last), 64'(w.last));
        end
      end
      if (s_axis_tvalid && s_axis_tready) begin
        pending.push_back(s_axis_tdata);
        if (pending.size() == LANES || s_axis_tlast) begin
          w.data = '0;
          w.keep = '0;
          w.last = s_axis_tlast;
          for (int i = 0; i < pending.size(); i++) begin
            w.data[i*IN_W +: IN_W] = pending[i];
            w.keep[i]              = 1'b1;
          end
          expq.push_back(w);
          pending.delete();
        end
      end
    end
  end

  task automatic send_beat(input logic [IN_W-1:0] d, input logic l, output int tries);
    bit ok;
    ok    = 1'b0;
    tries = 0;
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    while (!ok && tries < 200) begin
      @(negedge ap_clk);
      ok = s_axis_tready;
      tries++;
      @(posedge ap_clk);
      #1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: beat %0h not accepted, expected accept within 200 cycles", d);
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic expect_word(input string name, input logic [OUT_W-1:0] d,
                             input logic [LANES-1:0] k, input logic l);
    word_t w;
    int n;
    n = 0;
    while (got.size() == 0 && n < 50) begin
      @(posedge ap_clk);
      #1;
      n++;
    end
    if (got.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: got no word, expected %0h", name, d);
    end else begin
      w = got.pop_front();
      check({name, "_data"}, 64'(w.data), 64'(d));
      check({name, "_keep"}, 64'(w.keep), 64'(k));
      check({name, "_last"}, 64'(w.last), 64'(l));
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge ap_clk);
      #1;
    end
  endtask

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: simulation still running, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    int tries;
    int len;
    ap_rst          = 1'b1;
    s_axis_tdata    = '0;
    s_axis_tvalid   = 1'b0;
    s_axis_tlast    = 1'b0;
    m_axis_0_tready = 1'b1;
    repeat (10) @(posedge ap_clk);
    #1;
    ap_rst = 1'b0;
    @(negedge ap_clk);
    check("release_tready", 64'(s_axis_tready), 64'(1));
    @(posedge ap_clk);
    #1;

    // Pack one word, with 1-cycle output latency.
    got.delete();
    send_beat(8'hDE, 1'b0, tries);
    send_beat(8'hBC, 1'b0, tries);
    send_beat(8'h0A, 1'b0, tries);
    send_beat(8'h00, 1'b0, tries);
    check("pre_latency_valid", 64'(m_axis_0_tvalid), 64'(0));
    send_beat(8'h00, 1'b0, tries);
    check("latency_valid", 64'(m_axis_0_tvalid), 64'(1));
    check("latency_data", 64'(m_axis_0_tdata), 64'h00000ABCDE);
    expect_word("one_word", 40'h00000ABCDE, 5'b11111, 1'b0);
    idle(5);
    check("one_word_count", 64'(got.size()), 64'(0));

    // Continuous stream.
    watch_ready = 1'b1;
    for (int i = 1; i <= 10; i++) send_beat(8'(i), i == 10, tries);
    expect_word("stream_w0", 40'h0504030201, 5'b11111, 1'b0);
    expect_word("stream_w1", 40'h0A09080706, 5'b11111, 1'b1);
    watch_ready = 1'b0;

    // Short frame, then a one-beat frame in a fresh word.
    send_beat(8'hAA, 1'b0, tries);
    send_beat(8'hBB, 1'b1, tries);
    expect_word("short", 40'h000000BBAA, 5'b00011, 1'b1);
    send_beat(8'h11, 1'b1, tries);
    expect_word("one_beat", 40'h0000000011, 5'b00001, 1'b1);

    // Backpressure on a frame ending exactly on the last lane.
    idle(2);
    got.delete();
    m_axis_0_tready = 1'b0;
    for (int i = 0; i < LANES; i++) send_beat(8'(8'h21 + i), i == LANES - 1, tries);
    for (int c = 0; c < 6; c++) begin
      @(negedge ap_clk);
      check("bp_s_tready", 64'(s_axis_tready), 64'(0));
      check("bp_tdata", 64'(m_axis_0_tdata), 64'h2524232221);
      check("bp_tkeep", 64'(m_axis_0_tkeep), 64'(5'b11111));
      check("bp_tlast", 64'(m_axis_0_tlast), 64'(1));
      @(posedge ap_clk);
      #1;
    end
    m_axis_0_tready = 1'b1;
    send_beat(8'h30, 1'b1, tries);
    check("bp_resume_tries", 64'(tries), 64'(1));
    check("bp_reload_valid", 64'(m_axis_0_tvalid), 64'(1));
    check("bp_reload_data", 64'(m_axis_0_tdata), 64'h0000000030);
    expect_word("bp_word", 40'h2524232221, 5'b11111, 1'b1);
    expect_word("bp_next", 40'h0000000030, 5'b00001, 1'b1);

    // Reset mid-word discards the partial word.
    idle(2);
    got.delete();
    send_beat(8'h01, 1'b0, tries);
    send_beat(8'h02, 1'b0, tries);
    send_beat(8'h03, 1'b0, tries);
    ap_rst = 1'b1;
    @(posedge ap_clk);
    #1;
    ap_rst = 1'b0;
    for (int i = 0; i < LANES; i++) send_beat(8'(8'h10 + i), 1'b0, tries);
    expect_word("rst_mid", 40'h1413121110, 5'b11111, 1'b0);
    idle(5);
    check("rst_mid_count", 64'(got.size()), 64'(0));

    // Random valid/ready frames against the model.
    rand_ready = 1'b1;
    fork
      begin
        while (rand_ready) begin
          @(posedge ap_clk);
          #1;
          m_axis_0_tready = 1'($urandom_range(0, 1));
        end
      end
      begin
        for (int f = 0; f < 40; f++) begin
          len = $urandom_range(1, 12);
          for (int b = 0; b < len; b++) begin
            idle($urandom_range(0, 2));
            send_beat(8'($urandom), b == len - 1, tries);
          end
        end
        rand_ready = 1'b0;
      end
    join
    m_axis_0_tready = 1'b1;
    for (int n = 0; n < 100 && expq.size() != 0; n++) idle(1);
    check("random_drain", 64'(expq.size()), 64'(0));
    got.delete();
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
